modsum_feeder: RTL and testbench

Upstream operand front end for the 8-bit modulo accumulator. It accepts a modulus via a config handshake and operands via a valid/ready stream. It reduces each operand below the modulus, drives the accumulator's operand and inverted-modulus inputs, and emits a result-valid strobe, together with a shadow sum, aligned to the cycle in which the accumulator output reflects each operand. The accumulator has a two-register feedback loop, so it holds two interleaved sums; this block uses only the even lane and drives zero on the odd lane.

---
 rtl/modsum_feeder_if.sv | 23 ++
 rtl/modsum_feeder.sv | 80 ++++++++
 tb/tb_modsum_feeder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/modsum_feeder_if.sv
// modsum_feeder_if: config, operand, clear and accumulator-side signals of the modulo accumulator front end
interface modsum_feeder_if #(parameter int W = 8);
  logic         cfg_valid;
  logic [W-1:0] cfg_p;
  logic         cfg_ready;
  logic         op_valid;
  logic [W-1:0] op_data;
  logic         op_ready;
  logic         clr;
  logic [W-1:0] acc_a;
  logic [W-1:0] acc_p_rev;
  logic         res_valid;
  logic [W-1:0] res_sum;
  logic         err_cfg;
  modport master (
    output cfg_valid, cfg_p, op_valid, op_data, clr,
    input  cfg_ready, op_ready, acc_a, acc_p_rev, res_valid, res_sum, err_cfg
  );
  modport slave (
    input  cfg_valid, cfg_p, op_valid, op_data, clr,
    output cfg_ready, op_ready, acc_a, acc_p_rev, res_valid, res_sum, err_cfg
  );
endinterface

// File: rtl/modsum_feeder.sv
// modsum_feeder: reduces operands below P, feeds the even lane of the modulo accumulator, tracks a shadow sum
module modsum_feeder #(parameter int W = 8) (
  input logic            clk,
  input logic            rst_n,
  modsum_feeder_if.slave io_if
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t       r_state;
  logic [W-1:0] r_p, r_p_rev, r_hold, r_shadow, r_acc_a, r_d1_s, r_d2_s, r_res_sum;
  logic         r_hold_v, r_clr_pend, r_phase, r_d1_v, r_d2_v, r_res_v, r_err;
  logic         w_cfg_ready, w_op_ready, w_cfg_xfer, w_op_xfer, w_reduce, w_corr, w_issue_op, w_issue;
  logic [W-1:0] w_val, w_new;
  logic [W:0]   w_sum;
  assign w_cfg_ready = !r_hold_v && !r_clr_pend && r_shadow == '0 && !r_d1_v && !r_d2_v;
  assign w_op_ready  = r_state == RUN && !r_hold_v && !r_clr_pend;
  assign w_cfg_xfer  = io_if.cfg_valid && w_cfg_ready;
  assign w_op_xfer   = io_if.op_valid && w_op_ready;
  assign w_reduce    = r_hold_v && r_hold >= r_p;
  assign w_corr      = r_clr_pend && !r_hold_v && r_shadow != '0;
  assign w_issue_op  = r_phase && r_hold_v && !w_reduce;
  assign w_issue     = w_issue_op || (r_phase && w_corr);
  // with no operand held, the issued value is the clear correction
  assign w_val = r_hold_v ? r_hold : r_p - r_shadow;
  assign w_sum = {1'b0, r_shadow} + {1'b0, w_val};
  assign w_new = w_sum >= {1'b0, r_p} ? w_sum[W-1:0] - r_p : w_sum[W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_p        <= '0;
      r_p_rev    <= '1;
      r_hold     <= '0;
      r_hold_v   <= 1'b0;
      r_clr_pend <= 1'b0;
      r_shadow   <= '0;
      r_phase    <= 1'b0;
      r_acc_a    <= '0;
      r_d1_v     <= 1'b0;
      r_d1_s     <= '0;
      r_d2_v     <= 1'b0;
      r_d2_s     <= '0;
      r_res_v    <= 1'b0;
      r_res_sum  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      r_err   <= w_cfg_xfer && io_if.cfg_p < W'(2);
      if (w_cfg_xfer && io_if.cfg_p >= W'(2)) begin
        r_p     <= io_if.cfg_p;
        r_p_rev <= ~io_if.cfg_p;
        r_state <= RUN;
      end
      r_acc_a   <= w_issue ? w_val : '0;
      r_d1_v    <= w_issue;
      r_d1_s    <= w_new;
      r_d2_v    <= r_d1_v;
      r_d2_s    <= r_d1_s;
      r_res_v   <= r_d2_v;
      r_res_sum <= r_d2_v ? r_d2_s : r_res_sum;
      if (w_op_xfer) begin
        r_hold   <= io_if.op_data;
        r_hold_v <= 1'b1;
      end else if (w_reduce) begin
        r_hold <= r_hold - r_p;
      end else if (w_issue_op) begin
        r_hold_v <= 1'b0;
      end
      if (w_issue) r_shadow <= w_new;
      // a pending clear retires once nothing is held and either shadow is already 0 or the correction issues
      if (io_if.clr) r_clr_pend <= 1'b1;
      else if (r_clr_pend && !r_hold_v && (r_shadow == '0 || r_phase)) r_clr_pend <= 1'b0;
    end
  end
  assign io_if.cfg_ready = w_cfg_ready;
  assign io_if.op_ready  = w_op_ready;
  assign io_if.acc_a     = r_acc_a;
  assign io_if.acc_p_rev = r_p_rev;
  assign io_if.res_valid = r_res_v;
  assign io_if.res_sum   = r_res_sum;
  assign io_if.err_cfg   = r_err;
endmodule

// File: tb/tb_modsum_feeder.sv
// tb_modsum_feeder: scoreboard bench with a behavioural two-register modulo accumulator
module tb_modsum_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  modsum_feeder_if #(.W(8)) bus();
  modsum_feeder #(.W(8)) dut (.clk(clk), .rst_n(rst_n), .io_if(bus));
  typedef struct {logic [7:0] a; logic [7:0] s;} exp_t;
  typedef struct {logic [7:0] op; logic [7:0] a; logic [7:0] s;} vec_t;
  exp_t sb[$];
  vec_t tbl[7];
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // accumulator: two registers in a modular feedback loop, powering up at 0
  logic [7:0] s1 = '0, s2 = '0;
  logic [7:0] pm;
  logic [8:0] asum;
  assign pm   = ~bus.acc_p_rev;
  assign asum = {1'b0, bus.acc_a} + {1'b0, s2};
  always @(posedge clk) begin
    s1 <= (pm > 8'd1 && asum >= {1'b0, pm}) ? asum[7:0] - pm : asum[7:0];
    s2 <= s1;
  end
  logic tb_phase;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_phase <= 1'b0;
    else tb_phase <= ~tb_phase;
  logic [7:0] h1 = '0, h2 = '0;
  always @(negedge clk) begin
    h1 <= bus.acc_a;
    h2 <= h1;
    if (bus.acc_a != 0) chk("lane_phase", {31'd0, tb_phase}, 0);
    if (bus.res_valid) begin
      if (sb.size() == 0) chk("unexpected_res_valid", 1, 0);
      else begin
        chk("res_sum", {24'd0, bus.res_sum}, {24'd0, sb[0].s});
        chk("acc_a_issued", {24'd0, h2}, {24'd0, sb[0].a});
        chk("acc_out_vs_res_sum", {24'd0, s2}, {24'd0, bus.res_sum});
        void'(sb.pop_front());
      end
    end
  end
  task automatic send_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] s, input logic c);
    bus.op_valid = 1'b1;
    bus.op_data  = op;
    for (int i = 0; i < 200 && !bus.op_ready; i++) @(negedge clk);
    if (!bus.op_ready) begin
      chk("op_ready_timeout", 0, 1);
      bus.op_valid = 1'b0;
    end else begin
      bus.clr = c;
      sb.push_back('{a, s});
      @(posedge clk);
      #1 bus.op_valid = 1'b0;
      bus.clr = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic send_cfg(input logic [7:0] p);
    bus.cfg_valid = 1'b1;
    bus.cfg_p     = p;
    for (int i = 0; i < 200 && !bus.cfg_ready; i++) @(negedge clk);
    if (!bus.cfg_ready) chk("cfg_ready_timeout", 0, 1);
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    @(negedge clk);
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_acc_a"}, {24'd0, bus.acc_a}, 0);
    chk({tag, "_acc_p_rev"}, {24'd0, bus.acc_p_rev}, 32'hFF);
    chk({tag, "_res_valid"}, {31'd0, bus.res_valid}, 0);
    chk({tag, "_res_sum"}, {24'd0, bus.res_sum}, 0);
    chk({tag, "_err_cfg"}, {31'd0, bus.err_cfg}, 0);
    chk({tag, "_cfg_ready"}, {31'd0, bus.cfg_ready}, 1);
    chk({tag, "_op_ready"}, {31'd0, bus.op_ready}, 0);
  endtask
  int  lat;
  logic seen;
  initial begin
    tbl[0] = '{8'd3,   8'd3, 8'd3};
    tbl[1] = '{8'd5,   8'd5, 8'd1};
    tbl[2] = '{8'd6,   8'd6, 8'd0};
    tbl[3] = '{8'd200, 8'd4, 8'd4};
    tbl[4] = '{8'd13,  8'd6, 8'd3};
    tbl[5] = '{8'd7,   8'd0, 8'd3};
    tbl[6] = '{8'd254, 8'd2, 8'd5};
    bus.cfg_valid = 1'b0;
    bus.cfg_p     = '0;
    bus.op_valid  = 1'b0;
    bus.op_data   = '0;
    bus.clr       = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    send_cfg(8'd1);
    chk("err_cfg_pulse", {31'd0, bus.err_cfg}, 1);
    chk("idle_op_ready", {31'd0, bus.op_ready}, 0);
    chk("idle_p_rev", {24'd0, bus.acc_p_rev}, 32'hFF);
    @(negedge clk);
    chk("err_cfg_one_cycle", {31'd0, bus.err_cfg}, 0);
    send_cfg(8'd7);
    chk("p_rev_7", {24'd0, bus.acc_p_rev}, 32'hF8);
    chk("cfg7_no_err", {31'd0, bus.err_cfg}, 0);
    chk("run_op_ready", {31'd0, bus.op_ready}, 1);
    for (int i = 0; i < 7; i++) send_op(tbl[i].op, tbl[i].a, tbl[i].s, 1'b0);
    drain();
    chk("cfg_blocked_by_shadow", {31'd0, bus.cfg_ready}, 0);
    bus.cfg_valid = 1'b1;
    bus.cfg_p     = 8'd9;
    repeat (4) begin
      @(negedge clk);
      chk("held_cfg_no_err", {31'd0, bus.err_cfg}, 0);
    end
    bus.cfg_valid = 1'b0;
    chk("held_cfg_p_rev", {24'd0, bus.acc_p_rev}, 32'hF8);
    sb.push_back('{8'd2, 8'd0});
    pulse_clr();
    drain();
    chk("cfg_ready_after_clr", {31'd0, bus.cfg_ready}, 1);
    pulse_clr();
    repeat (8) @(negedge clk);
    chk("op_ready_after_idle_clr", {31'd0, bus.op_ready}, 1);
    bus.op_valid = 1'b1;
    bus.op_data  = 8'd200;
    sb.push_back('{8'd4, 8'd4});
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (bus.acc_a != 0) break;
      if (bus.op_ready) seen = 1'b1;
    end
    chk("reduce_latency_30_31", (lat == 30 || lat == 31) ? 1 : lat, 1);
    chk("reduce_op_ready_low", {31'd0, seen}, 0);
    chk("reduce_acc_a", {24'd0, bus.acc_a}, 4);
    drain();
    send_op(8'd6, 8'd6, 8'd3, 1'b1);
    sb.push_back('{8'd4, 8'd0});
    for (int i = 0; i < 10 && bus.acc_a != 8'd6; i++) @(negedge clk);
    chk("simul_first_issue", {24'd0, bus.acc_a}, 6);
    chk("simul_op_ready_low", {31'd0, bus.op_ready}, 0);
    drain();
    chk("simul_op_ready_after", {31'd0, bus.op_ready}, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_op_ready", {31'd0, bus.op_ready}, 0);
    send_cfg(8'd11);
    chk("p_rev_11", {24'd0, bus.acc_p_rev}, 32'hF4);
    send_op(8'd10, 8'd10, 8'd10, 1'b0);
    send_op(8'd5, 8'd5, 8'd4, 1'b0);
    send_op(8'd22, 8'd0, 8'd4, 1'b0);
    send_op(8'd250, 8'd8, 8'd1, 1'b0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
